// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - shared constants and enums for the input-delay calibration controller
// Purpose: lane/tap geometry, calibration timing and the command/state encodings
//          used by idelay_calib_ctrl and idelay_tap_bank.
// Ports:   none (package).
package params_pkg;

  localparam int NUM_LANES       = 11;
  localparam int TAP_W           = 9;
  localparam int TAP_DEFAULT     = 256;
  localparam int MAX_TAP         = 511;
  localparam int RST_HOLD_CYCLES = 4;
  localparam int CAL_CYCLES      = 64;

  localparam int LANE_W = 4;
  // Wide enough for the longer of the two phase counts.
  localparam int CNT_W  = $clog2(CAL_CYCLES + 1);

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_INC   = 2'b10,
    CMD_DEC   = 2'b11
  } tap_cmd_e;

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    CAL   = 2'b01,
    READY = 2'b10
  } cal_state_e;

endpackage

// File: rtl/idelay_tap_bank.sv
// rtl/idelay_tap_bank.sv - per-lane delay tap registers with write/inc/dec and saturation
// Purpose: holds NUM_LANES tap registers; applies one command per cycle when enabled,
//          reports rejected commands and saturating updates as registered pulses.
// Ports:   i_clk, i_rst_n     clock, async active-low reset
//          i_clear            force all taps back to TAP_DEFAULT next cycle
//          i_en               commands may be applied this cycle
//          i_cmd, i_lane, i_value  tap command, target lane, write value
//          o_taps             flattened tap vector, lane n at [n*TAP_W +: TAP_W]
//          o_cmd_err, o_tap_sat    single-cycle pulses
module idelay_tap_bank
  import params_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clear,
  input  logic                       i_en,
  input  tap_cmd_e                   i_cmd,
  input  logic [LANE_W-1:0]          i_lane,
  input  logic [TAP_W-1:0]           i_value,
  output logic [NUM_LANES*TAP_W-1:0] o_taps,
  output logic                       o_cmd_err,
  output logic                       o_tap_sat
);

  logic [TAP_W-1:0] taps_q [NUM_LANES];
  logic [TAP_W-1:0] taps_d [NUM_LANES];
  logic [TAP_W-1:0] cur_tap;
  logic [TAP_W-1:0] new_tap;
  logic             lane_ok;
  logic             do_upd;
  logic             err_d, err_q;
  logic             sat_d, sat_q;

  always_comb begin
    lane_ok = (i_lane < LANE_W'(NUM_LANES));

    // Mux the addressed tap by comparison so out-of-range lanes never index the array.
    cur_tap = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (i_lane == LANE_W'(i)) cur_tap = taps_q[i];
    end

    new_tap = cur_tap;
    do_upd  = 1'b0;
    err_d   = 1'b0;
    sat_d   = 1'b0;

    if (i_cmd != CMD_NONE) begin
      if (!i_en || !lane_ok) begin
        err_d = 1'b1;
      end else begin
        do_upd = 1'b1;
        case (i_cmd)
          CMD_WRITE: begin
            // Zero-extended compare keeps the clamp meaningful if TAP_W outgrows MAX_TAP.
            if ({1'b0, i_value} > (TAP_W + 1)'(MAX_TAP)) begin
              new_tap = TAP_W'(MAX_TAP);
              sat_d   = 1'b1;
            end else begin
              new_tap = i_value;
            end
          end
          CMD_INC: begin
            if (cur_tap == TAP_W'(MAX_TAP)) sat_d = 1'b1;
            else                            new_tap = cur_tap + 1'b1;
          end
          CMD_DEC: begin
            if (cur_tap == '0) sat_d = 1'b1;
            else               new_tap = cur_tap - 1'b1;
          end
          default: ;
        endcase
      end
    end

    for (int i = 0; i < NUM_LANES; i++) begin
      taps_d[i] = taps_q[i];
      if (i_clear) begin
        taps_d[i] = TAP_W'(TAP_DEFAULT);
      end else if (do_upd && (i_lane == LANE_W'(i))) begin
        taps_d[i] = new_tap;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) taps_q[i] <= TAP_W'(TAP_DEFAULT);
      err_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) taps_q[i] <= taps_d[i];
      err_q <= err_d;
      sat_q <= sat_d;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_flat
    assign o_taps[g*TAP_W +: TAP_W] = taps_q[g];
  end

  assign o_cmd_err = err_q;
  assign o_tap_sat = sat_q;

endmodule

// File: rtl/idelay_calib_ctrl.sv
// rtl/idelay_calib_ctrl.sv - calibration/readiness controller for the deserializer input delays
// Purpose: sequences HOLD -> CAL -> READY after reset or restart, gates tap commands
//          until ready, and owns the per-lane tap bank.
// Ports:   i_clk, i_rst_n     reference clock, async active-low reset
//          i_cal_restart      level-sensitive recalibration request
//          i_tap_cmd, i_tap_lane, i_tap_value  tap command interface
//          o_rdy              calibration complete, taps valid
//          o_taps             flattened per-lane taps
//          o_cmd_err, o_tap_sat    rejected-command / saturation pulses
module idelay_calib_ctrl
  import params_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_cal_restart,
  input  logic [1:0]                 i_tap_cmd,
  input  logic [LANE_W-1:0]          i_tap_lane,
  input  logic [TAP_W-1:0]           i_tap_value,
  output logic                       o_rdy,
  output logic [NUM_LANES*TAP_W-1:0] o_taps,
  output logic                       o_cmd_err,
  output logic                       o_tap_sat
);

  cal_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic             tap_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_cal_restart) begin
      state_d = HOLD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == CNT_W'(RST_HOLD_CYCLES - 1)) begin
            state_d = CAL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        CAL: begin
          if (cnt_q == CNT_W'(CAL_CYCLES - 1)) begin
            state_d = READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        READY: ;
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    // Registered from the next state so o_rdy is high on the first READY cycle.
    rdy_d  = (state_d == READY);
    tap_en = rdy_q && !i_cal_restart;
  end

  idelay_tap_bank u_tap_bank (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (i_cal_restart),
    .i_en      (tap_en),
    .i_cmd     (tap_cmd_e'(i_tap_cmd)),
    .i_lane    (i_tap_lane),
    .i_value   (i_tap_value),
    .o_taps    (o_taps),
    .o_cmd_err (o_cmd_err),
    .o_tap_sat (o_tap_sat)
  );

  assign o_rdy = rdy_q;

endmodule

// File: tb/tb_idelay_calib_ctrl.sv
// tb/tb_idelay_calib_ctrl.sv - self-checking bench for idelay_calib_ctrl
module tb_idelay_calib_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_cal_restart = 1'b0;
  logic [1:0]  i_tap_cmd = 2'd0;
  logic [3:0]  i_tap_lane = 4'd0;
  logic [8:0]  i_tap_value = 9'd0;
  logic        o_rdy;
  logic [98:0] o_taps;
  logic        o_cmd_err;
  logic        o_tap_sat;

  int total = 0;
  int bad   = 0;

  // Model state: taps per lane, cycles since last reset/restart, last-cycle pulses.
  int m_tap [11];
  int m_cnt;
  bit m_rdy;
  bit m_err;
  bit m_sat;

  idelay_calib_ctrl dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_cal_restart (i_cal_restart),
    .i_tap_cmd     (i_tap_cmd),
    .i_tap_lane    (i_tap_lane),
    .i_tap_value   (i_tap_value),
    .o_rdy         (o_rdy),
    .o_taps        (o_taps),
    .o_cmd_err     (o_cmd_err),
    .o_tap_sat     (o_tap_sat)
  );

  always #5 i_clk = ~i_clk;

  function automatic int lane(input int n);
    return int'(o_taps[n*9 +: 9]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_rdy = 0;
    m_err = 0;
    m_sat = 0;
    foreach (m_tap[i]) m_tap[i] = 256;
  endtask

  task automatic compare_all(input string tag);
    chk($sformatf("%s rdy", tag), int'(o_rdy), int'(m_rdy));
    chk($sformatf("%s err", tag), int'(o_cmd_err), int'(m_err));
    chk($sformatf("%s sat", tag), int'(o_tap_sat), int'(m_sat));
    for (int i = 0; i < 11; i++) chk($sformatf("%s lane%0d", tag, i), lane(i), m_tap[i]);
  endtask

  // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
  task automatic step(input int cmd, input int ln, input int val, input bit rs);
    bit en;
    i_tap_cmd     = 2'(cmd);
    i_tap_lane    = 4'(ln);
    i_tap_value   = 9'(val);
    i_cal_restart = rs;
    @(posedge i_clk);
    en    = m_rdy && !rs;
    m_err = 0;
    m_sat = 0;
    if (cmd != 0) begin
      if (!en || ln >= 11) m_err = 1;
      else begin
        case (cmd)
          1: if (val > 511) begin m_tap[ln] = 511; m_sat = 1; end else m_tap[ln] = val;
          2: if (m_tap[ln] == 511) m_sat = 1; else m_tap[ln] = m_tap[ln] + 1;
          3: if (m_tap[ln] == 0) m_sat = 1; else m_tap[ln] = m_tap[ln] - 1;
          default: ;
        endcase
      end
    end
    if (rs) begin
      m_cnt = 0;
      foreach (m_tap[i]) m_tap[i] = 256;
    end else if (m_cnt < 100000) begin
      m_cnt++;
    end
    m_rdy = (m_cnt >= 68);
    @(negedge i_clk);
    compare_all("model");
  endtask

  task automatic idle();
    step(0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge i_clk);
    chk("reset rdy", int'(o_rdy), 0);
    chk("reset err", int'(o_cmd_err), 0);
    chk("reset sat", int'(o_tap_sat), 0);
    for (int i = 0; i < 11; i++) chk($sformatf("reset lane%0d", i), lane(i), 256);

    // Release and run to ready; inc on lane 2 at cycle 10 must be rejected.
    i_rst_n = 1'b1;
    for (int k = 1; k <= 68; k++) begin
      if (k == 10) step(2, 2, 0, 0);
      else idle();
      if (k == 10) chk("early inc err", int'(o_cmd_err), 1);
      if (k == 67) chk("rdy at 67", int'(o_rdy), 0);
      if (k == 68) chk("rdy at 68", int'(o_rdy), 1);
    end
    chk("lane2 after early inc", lane(2), 256);

    step(1, 3, 100, 0);
    chk("write lane3", lane(3), 100);
    chk("write other lane", lane(4), 256);
    step(1, 3, 511, 0);
    chk("write lane3 max", lane(3), 511);
    chk("write max no sat", int'(o_tap_sat), 0);

    step(1, 0, 511, 0);
    step(2, 0, 0, 0);
    chk("inc sat pulse", int'(o_tap_sat), 1);
    chk("inc sat lane0", lane(0), 511);
    chk("inc sat no err", int'(o_cmd_err), 0);
    idle();
    chk("sat single pulse", int'(o_tap_sat), 0);

    step(1, 10, 0, 0);
    step(3, 10, 0, 0);
    chk("dec sat pulse", int'(o_tap_sat), 1);
    chk("dec sat lane10", lane(10), 0);

    step(2, 5, 0, 0);
    step(2, 5, 0, 0);
    chk("two inc lane5", lane(5), 258);
    step(3, 4, 0, 0);
    chk("dec lane4", lane(4), 255);

    step(1, 11, 5, 0);
    chk("bad lane err", int'(o_cmd_err), 1);
    chk("bad lane no sat", int'(o_tap_sat), 0);
    step(2, 15, 0, 0);
    chk("lane15 err", int'(o_cmd_err), 1);
    idle();
    chk("err single pulse", int'(o_cmd_err), 0);

    // Restart in READY.
    step(1, 1, 7, 0);
    chk("lane1 = 7", lane(1), 7);
    step(0, 0, 0, 1);
    chk("restart rdy drop", int'(o_rdy), 0);
    chk("restart lane1", lane(1), 256);
    chk("restart lane5", lane(5), 256);

    // Restart mid-CAL: progress is discarded.
    for (int k = 1; k <= 30; k++) idle();
    step(0, 0, 0, 1);
    for (int k = 1; k <= 68; k++) begin
      idle();
      if (k == 67) chk("midcal rdy at 67", int'(o_rdy), 0);
      if (k == 68) chk("midcal rdy at 68", int'(o_rdy), 1);
    end

    // Async reset while ready with a modified tap, between edges.
    step(1, 4, 9, 0);
    chk("lane4 = 9", lane(4), 9);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async rdy ready", int'(o_rdy), 0);
    chk("async lane4", lane(4), 256);
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Async reset mid-CAL.
    for (int k = 1; k <= 20; k++) idle();
    step(1, 6, 3, 0);
    chk("cal write err", int'(o_cmd_err), 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async rdy cal", int'(o_rdy), 0);
    chk("async err cal", int'(o_cmd_err), 0);
    chk("async lane6 cal", lane(6), 256);
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 1; k <= 68; k++) idle();
    chk("ready after reset", int'(o_rdy), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
